// File: rtl/result_writeback_pkg.sv
// Shared FPU definitions used by the rounder and by result_writeback.
// Provides the accrued-flag bit positions, the canonical quiet-NaN encoding
// and the rounding-mode encodings.
package result_writeback_pkg;

    // Bit positions inside the 5-bit {NV,DZ,OF,UF,NX} flag vector
    localparam int unsigned FLAG_NV = 32'd4;
    localparam int unsigned FLAG_DZ = 32'd3;
    localparam int unsigned FLAG_OF = 32'd2;
    localparam int unsigned FLAG_UF = 32'd1;
    localparam int unsigned FLAG_NX = 32'd0;
    localparam int unsigned FLAGS_W = 32'd5;

    // Canonical single-precision quiet NaN
    localparam logic [22:0] CANON_NAN_MANT = 23'h400000;
    localparam logic [31:0] CANON_NAN_WORD = 32'h7FC00000;

    // Rounding-mode encodings
    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rm_e;

endpackage

// File: rtl/result_fifo2.sv
// Two-entry FIFO with registered ready/valid.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   push_i, wdata_i   : write request and data (ignored when ready_o=0)
//   pop_i             : read request (ignored when valid_o=0)
//   rdata_o, valid_o  : head entry and its presence
//   ready_o           : space available (registered, no path from pop_i)
module result_fifo2 #(
    parameter int W = 37
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         valid_o,
    output logic         ready_o
);

    logic [W-1:0] mem_q [2];
    logic         wptr_q, wptr_d;
    logic         rptr_q, rptr_d;
    logic [1:0]   count_q, count_d;
    logic         valid_q, valid_d;
    logic         ready_q, ready_d;
    logic         push_s;
    logic         pop_s;

    assign push_s  = push_i & ready_q;
    assign pop_s   = pop_i & valid_q;
    assign rdata_o = mem_q[rptr_q];
    assign valid_o = valid_q;
    assign ready_o = ready_q;

    // Next-state for pointers, occupancy and the registered handshake flags
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_s) begin
            wptr_d = ~wptr_q;
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = ~rptr_q;
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        // Ready/valid are derived from the next count so they can be registered
        valid_d = (count_d != 2'd0);
        ready_d = (count_d != 2'd2);
    end

    // Control state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= 2'd0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    // Storage array, not reset: stale data is never visible while valid_o=0
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/result_writeback.sv
// Result writeback stage: packs rounded results and their exception flags,
// buffers them in a 2-entry FIFO, accumulates sticky fflags and counts
// retired results.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   Valid_i/Ready_o              : rounder handshake
//   Sign/Exp/Mant_result_i       : rounded fields
//   Invalid/Overflow/Underflow/Inexact_i, Inf_operand_i : raw flags
//   Valid_o/Ready_i              : consumer handshake
//   Result_o, Flags_o            : head packed float and its flags
//   Fflags_clr_i, Fflags_o       : clear / sticky accumulated flags
//   Retired_cnt_o                : number of popped results
module result_writeback
    import result_writeback_pkg::*;
#(
    parameter int                   PARM_EXP      = 8,
    parameter int                   PARM_MANT     = 23,
    parameter int                   PARM_XLEN     = 32,
    parameter logic [PARM_MANT-1:0] PARM_MANT_NAN = CANON_NAN_MANT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Valid_i,
    output logic                 Ready_o,
    input  logic                 Sign_result_i,
    input  logic [PARM_EXP-1:0]  Exp_result_i,
    input  logic [PARM_MANT-1:0] Mant_result_i,
    input  logic                 Invalid_i,
    input  logic                 Overflow_i,
    input  logic                 Underflow_i,
    input  logic                 Inexact_i,
    input  logic                 Inf_operand_i,
    output logic                 Valid_o,
    input  logic                 Ready_i,
    output logic [PARM_XLEN-1:0] Result_o,
    output logic [4:0]           Flags_o,
    input  logic                 Fflags_clr_i,
    output logic [4:0]           Fflags_o,
    output logic [31:0]          Retired_cnt_o
);

    localparam int W = PARM_XLEN + 5;

    logic [PARM_XLEN-1:0] pack_res_s;
    logic [4:0]           pack_flg_s;
    logic [W-1:0]         head_s;
    logic                 pop_s;
    logic [4:0]           fflags_q, fflags_d;
    logic [31:0]          retired_q, retired_d;

    // Pack the result and map raw rounder flags at push time
    always_comb begin
        pack_res_s = {Sign_result_i, Exp_result_i, Mant_result_i};
        pack_flg_s = 5'b00000;
        if (Invalid_i) begin
            pack_res_s = {1'b0, {PARM_EXP{1'b1}}, PARM_MANT_NAN};
        end else begin
            pack_res_s = {Sign_result_i, Exp_result_i, Mant_result_i};
        end
        pack_flg_s[FLAG_NV] = Invalid_i;
        pack_flg_s[FLAG_DZ] = 1'b0;
        // Overflow caused by an infinite operand is exact, not an overflow
        pack_flg_s[FLAG_OF] = Overflow_i & ~Inf_operand_i & ~Invalid_i;
        // Tininess alone is not an underflow; it must also be inexact
        pack_flg_s[FLAG_UF] = Underflow_i & Inexact_i & ~Invalid_i;
        pack_flg_s[FLAG_NX] = (Inexact_i | pack_flg_s[FLAG_OF]) & ~Invalid_i;
    end

    result_fifo2 #(
        .W(W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (Valid_i),
        .wdata_i ({pack_res_s, pack_flg_s}),
        .pop_i   (Ready_i),
        .rdata_o (head_s),
        .valid_o (Valid_o),
        .ready_o (Ready_o)
    );

    assign pop_s         = Valid_o & Ready_i;
    assign Result_o      = head_s[W-1:5];
    assign Flags_o       = head_s[4:0];
    assign Fflags_o      = fflags_q;
    assign Retired_cnt_o = retired_q;

    // Sticky flag accumulation; a clear wins over old state but not over a same-cycle pop
    always_comb begin
        fflags_d  = fflags_q;
        retired_d = retired_q;
        if (Fflags_clr_i) begin
            fflags_d = pop_s ? head_s[4:0] : 5'b00000;
        end else if (pop_s) begin
            fflags_d = fflags_q | head_s[4:0];
        end else begin
            fflags_d = fflags_q;
        end
        if (pop_s) begin
            retired_d = retired_q + 32'd1;
        end else begin
            retired_d = retired_q;
        end
    end

    // Accumulated flags and retired-count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fflags_q  <= 5'b00000;
            retired_q <= 32'd0;
        end else begin
            fflags_q  <= fflags_d;
            retired_q <= retired_d;
        end
    end

endmodule
